// File: rtl/load_store_unit32_if.sv
// Core-side request/response and byte-wide memory-side signals of the LSU.
// Valid/ready: a request transfers on the rising edge where req_valid and req_ready are both 1.
interface load_store_unit32_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  loadStoreMode;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  // The LSU itself.
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, loadStoreMode, mem_rdata, mem_ack,
    output req_ready, resp_valid, resp_data, resp_err, mem_req, mem_we, mem_addr, mem_wdata
  );

  // The surrounding core and memory.
  modport master (
    output req_valid, req_write, req_addr, req_wdata, loadStoreMode, mem_rdata, mem_ack,
    input  req_ready, resp_valid, resp_data, resp_err, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/load_store_unit32.sv
// Load/store unit: splits a 32-bit core access into big-endian byte transfers on an
// 8-bit memory port and reassembles/extends load data. All outputs come from flops.
module load_store_unit32 #(
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  load_store_unit32_if.slave   bus,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           write_q, write_d;
  logic           err_q, err_d;
  logic [2:0]     mode_q, mode_d;
  logic [N-1:0]   addr_q, addr_d;
  logic [1:0]     k_q, k_d;
  logic [N-1:0]   acc_q, acc_d;
  logic [N-1:0]   sh_q, sh_d;

  logic [1:0]     last_k;
  logic [N-1:0]   preload;
  logic [N-1:0]   load_ext;

  always_comb begin
    last_k = 2'd3;
    case (mode_q[1:0])
      2'b00:   last_k = 2'd0;
      2'b01:   last_k = 2'd1;
      default: last_k = 2'd3;
    endcase
  end

  // Store data is left-justified so the top byte is always the next one to send.
  always_comb begin
    preload = bus.req_wdata;
    case (bus.loadStoreMode[1:0])
      2'b00:   preload = bus.req_wdata << 24;
      2'b01:   preload = bus.req_wdata << 16;
      default: preload = bus.req_wdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    err_d   = err_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    k_d     = k_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          mode_d  = bus.loadStoreMode;
          addr_d  = bus.req_addr;
          k_d     = 2'd0;
          acc_d   = '0;
          sh_d    = preload;
          if (bus.loadStoreMode[1:0] == 2'b11) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = S_XFER;
          end
        end
      end
      S_XFER: begin
        if (bus.mem_ack) begin
          k_d    = k_q + 2'd1;
          addr_d = addr_q + 32'd1;
          sh_d   = sh_q << 8;
          if (!write_q) acc_d = {acc_q[N-9:0], bus.mem_rdata};
          if (k_q == last_k) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      mode_q  <= 3'd0;
      addr_q  <= '0;
      k_q     <= 2'd0;
      acc_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      err_q   <= err_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
    end
  end

  // mode_q[2] set means zero-extend; otherwise the top received bit is replicated.
  always_comb begin
    load_ext = acc_q;
    case (mode_q[1:0])
      2'b00:   load_ext = {{24{~mode_q[2] & acc_q[7]}}, acc_q[7:0]};
      2'b01:   load_ext = {{16{~mode_q[2] & acc_q[15]}}, acc_q[15:0]};
      default: load_ext = acc_q;
    endcase
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.mem_req    = (state_q == S_XFER);
  assign bus.mem_we     = (state_q == S_XFER) & write_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = sh_q[N-1:N-8];
  assign bus.resp_valid = (state_q == S_DONE);
  assign bus.resp_err   = (state_q == S_DONE) & err_q;
  assign bus.resp_data  = ((state_q == S_DONE) && !err_q && !write_q) ? load_ext : '0;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_load_store_unit32.sv
// Bench for load_store_unit32: byte memory with programmable wait states, directed
// cases followed by random loads/stores checked against a byte-array reference.
module tb_load_store_unit32;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;

  load_store_unit32_if ifc ();

  load_store_unit32 dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (ifc),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- memory model ----------------
  logic [7:0]  mem [0:255];
  int          wait_n = 0;
  int          wcnt = 0;
  int          unstable = 0;
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = '0;
  logic        prev_we = 1'b0;
  logic [7:0]  prev_wd = '0;
  logic [40:0] log_q[$];

  assign ifc.mem_ack   = ifc.mem_req && (wcnt == wait_n);
  assign ifc.mem_rdata = mem[ifc.mem_addr[7:0]];

  always @(posedge clk) begin
    if (ifc.mem_req) begin
      if (prev_wait && (ifc.mem_addr !== prev_addr || ifc.mem_we !== prev_we ||
                        ifc.mem_wdata !== prev_wd))
        unstable <= unstable + 1;
      if (ifc.mem_ack) begin
        log_q.push_back({ifc.mem_we, ifc.mem_addr, ifc.mem_we ? ifc.mem_wdata : 8'h00});
        if (ifc.mem_we) mem[ifc.mem_addr[7:0]] <= ifc.mem_wdata;
        wcnt      <= 0;
        prev_wait <= 1'b0;
      end else begin
        wcnt      <= wcnt + 1;
        prev_wait <= 1'b1;
        prev_addr <= ifc.mem_addr;
        prev_we   <= ifc.mem_we;
        prev_wd   <= ifc.mem_wdata;
      end
    end else begin
      wcnt      <= 0;
      prev_wait <= 1'b0;
    end
  end

  // ---------------- scoreboard / reference ----------------
  logic [40:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] m);
    int n;
    longint unsigned v;
    n = 1 << m[1:0];
    v = 0;
    for (int i = 0; i < n; i++) v = (v << 8) | longint'(mem[8'(a + 32'(i))]);
    if (!m[2] && (((v >> (8 * n - 1)) & 1) == 1)) v = v | ~((64'd1 << (8 * n)) - 1);
    return v[31:0];
  endfunction

  // ---------------- driver ----------------
  task automatic txn(input string tag, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [2:0] m, input int wt,
                     input bit hold, output logic [31:0] rd);
    logic [31:0] exp_data;
    logic        exp_err;
    int          n, exp_lat, lat, bad, u0;
    logic        er;
    n        = 1 << m[1:0];
    exp_err  = (m[1:0] == 2'b11);
    exp_data = (exp_err || w) ? 32'h0 : ref_load(a, m);
    exp_lat  = exp_err ? 1 : n * (wt + 1) + 1;
    exp_q.delete();
    if (!exp_err)
      for (int i = 0; i < n; i++)
        exp_q.push_back({w, a + 32'(i), w ? 8'(d >> (8 * (n - 1 - i))) : 8'h00});
    rd  = '0;
    er  = 1'bx;
    lat = 0;
    bad = 0;
    for (int i = 0; i < 50 && ifc.req_ready !== 1'b1; i++) @(negedge clk);
    @(negedge clk);
    wait_n = wt;
    log_q.delete();
    u0 = unstable;
    ifc.req_valid     = 1'b1;
    ifc.req_write     = w;
    ifc.req_addr      = a;
    ifc.req_wdata     = d;
    ifc.loadStoreMode = m;
    @(posedge clk);
    #1;
    if (!hold) ifc.req_valid = 1'b0;
    ifc.req_write     = $urandom_range(0, 1);
    ifc.req_addr      = $urandom;
    ifc.req_wdata     = $urandom;
    ifc.loadStoreMode = 3'($urandom_range(0, 7));
    for (int c = 1; c <= 120; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      if (ifc.resp_valid === 1'b1) begin
        lat = c;
        rd  = ifc.resp_data;
        er  = ifc.resp_err;
        break;
      end
      if (exp_err || ifc.mem_req !== 1'b1 || ifc.req_ready !== 1'b0) bad++;
    end
    if (ifc.mem_req !== 1'b0 || ifc.req_ready !== 1'b0) bad++;
    @(negedge clk);
    ifc.req_valid = 1'b0;
    @(posedge clk);
    #1;
    if (ifc.req_ready !== 1'b1 || ifc.resp_valid !== 1'b0) bad++;
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_data"}, 64'(rd), 64'(exp_data));
    check({tag, "_err"}, 64'(er), 64'(exp_err));
    check({tag, "_proto"}, 64'(bad), 64'd0);
    check({tag, "_stable"}, 64'(unstable - u0), 64'd0);
    check({tag, "_nbytes"}, 64'(log_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check({tag, "_byte"}, 64'(log_q[i]), 64'(exp_q[i]));
  endtask

  // ---------------- directed + random sequence ----------------
  logic [31:0] rd;
  int          rv;

  initial begin
    rst = 1'b1;
    ifc.req_valid     = 1'b0;
    ifc.req_write     = 1'b0;
    ifc.req_addr      = '0;
    ifc.req_wdata     = '0;
    ifc.loadStoreMode = 3'd0;
    for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    #12;
    check("rst_ready", 64'(ifc.req_ready), 64'd1);
    check("rst_resp_valid", 64'(ifc.resp_valid), 64'd0);
    check("rst_resp_data", 64'(ifc.resp_data), 64'd0);
    check("rst_resp_err", 64'(ifc.resp_err), 64'd0);
    check("rst_mem_req", 64'(ifc.mem_req), 64'd0);
    check("rst_mem_we", 64'(ifc.mem_we), 64'd0);
    check("rst_mem_addr", 64'(ifc.mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(ifc.mem_wdata), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    mem[8'h10] <= 8'h80;
    mem[8'h11] <= 8'h01;
    mem[8'h12] <= 8'h02;
    mem[8'h13] <= 8'h03;
    mem[8'hFF] <= 8'h7F;
    mem[8'h00] <= 8'h11;
    @(negedge clk);

    txn("lw10", 1'b0, 32'h10, 32'h0, 3'b010, 0, 1'b0, rd);
    check("lw10_val", 64'(rd), 64'h80010203);
    txn("lb10", 1'b0, 32'h10, 32'h0, 3'b000, 0, 1'b0, rd);
    check("lb10_val", 64'(rd), 64'hFFFFFF80);
    txn("lbu10", 1'b0, 32'h10, 32'h0, 3'b100, 0, 1'b0, rd);
    check("lbu10_val", 64'(rd), 64'h00000080);
    txn("lh10", 1'b0, 32'h10, 32'h0, 3'b001, 0, 1'b0, rd);
    check("lh10_val", 64'(rd), 64'hFFFF8001);
    txn("lhu10", 1'b0, 32'h10, 32'h0, 3'b101, 0, 1'b0, rd);
    check("lhu10_val", 64'(rd), 64'h00008001);
    txn("lb11", 1'b0, 32'h11, 32'h0, 3'b000, 0, 1'b0, rd);
    check("lb11_val", 64'(rd), 64'h00000001);

    txn("sw20", 1'b1, 32'h20, 32'hDEADBEEF, 3'b010, 0, 1'b0, rd);
    check("sw20_mem", 64'({mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]}), 64'hDEADBEEF);
    txn("sh30", 1'b1, 32'h30, 32'h1234ABCD, 3'b101, 0, 1'b0, rd);
    check("sh30_mem", 64'({mem[8'h30], mem[8'h31], mem[8'h32]}), 64'hABCD00);
    txn("sb40", 1'b1, 32'h40, 32'h1234ABCD, 3'b000, 0, 1'b0, rd);
    check("sb40_mem", 64'({mem[8'h40], mem[8'h41]}), 64'hCD00);

    txn("lw_wait3", 1'b0, 32'h10, 32'h0, 3'b010, 3, 1'b1, rd);
    check("lw_wait3_val", 64'(rd), 64'h80010203);
    txn("lh_wrap", 1'b0, 32'hFFFFFFFF, 32'h0, 3'b001, 0, 1'b0, rd);
    check("lh_wrap_val", 64'(rd), 64'h00007F11);
    txn("bad_mode", 1'b0, 32'h10, 32'h0, 3'b011, 0, 1'b0, rd);

    // Reset in the middle of a word load, after two bytes were acknowledged.
    @(negedge clk);
    wait_n = 0;
    ifc.req_valid     = 1'b1;
    ifc.req_write     = 1'b0;
    ifc.req_addr      = 32'h10;
    ifc.loadStoreMode = 3'b010;
    @(posedge clk);
    #1;
    ifc.req_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("mid_mem_req", 64'(ifc.mem_req), 64'd1);
    rst = 1'b1;
    #1;
    check("abort_mem_req", 64'(ifc.mem_req), 64'd0);
    check("abort_ready", 64'(ifc.req_ready), 64'd1);
    check("abort_resp", 64'(ifc.resp_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    rv = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (ifc.resp_valid !== 1'b0) rv++;
    end
    check("abort_no_resp", 64'(rv), 64'd0);
    txn("lw_after_rst", 1'b0, 32'h10, 32'h0, 3'b010, 0, 1'b0, rd);
    check("lw_after_rst_val", 64'(rd), 64'h80010203);

    for (int t = 0; t < 40; t++) begin
      txn("rand", 1'($urandom_range(0, 1)), $urandom, $urandom,
          3'($urandom_range(0, 7)), $urandom_range(0, 2), 1'($urandom_range(0, 1)), rd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
